// File: rtl/parity_pkg.sv
// Shared definitions for the parity-protected serial link.
// Holds the transmitter state encoding and the fixed line levels used by
// the frame format (start low, stop high, idle high).
package parity_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/parity_gen.sv
// Combinational parity generator.
// With ODD_PARITY=0 the returned bit makes data plus parity bit hold an
// even number of ones. With ODD_PARITY=1 the count of ones is odd.
// Ports:
//   data  in  DATA_W  word to protect
//   pbit  out 1       parity bit for data
module parity_gen #(
  parameter int DATA_W     = 4,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic [DATA_W-1:0] data,
  output logic              pbit
);

  assign pbit = (^data) ^ ODD_PARITY;

endmodule

// File: rtl/parity_serial_tx.sv
// Serial frame transmitter for the parity-protected link.
// It accepts a word over a valid/ready handshake and latches the word
// together with its parity bit. It then sends the frame on tx_out:
//   start(0) | data bits LSB first | parity | stop(1)
// Each bit is held for CLKS_PER_BIT clocks.
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   data_in     in   word to transmit (DATA_W bits)
//   data_valid  in   producer offers data_in
//   data_ready  out  a word can be accepted this cycle
//   tx_out      out  serial line, idles high
//   busy        out  a frame is in progress
//   pbit_out    out  parity of the word being sent or last sent
//   done        out  one-cycle pulse at the end of the stop bit
// All outputs are registered.
module parity_serial_tx
  import parity_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter bit ODD_PARITY   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              pbit_out,
  output logic              done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  tx_state_t         state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [IW-1:0]     bit_idx, idx_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [DATA_W-1:0] shreg_shift;
  logic              tx_n, busy_n, ready_n, done_n, pbit_n;
  logic              gen_pbit;
  logic              bit_end;

  parity_gen #(
    .DATA_W     (DATA_W),
    .ODD_PARITY (ODD_PARITY)
  ) u_parity_gen (
    .data (data_in),
    .pbit (gen_pbit)
  );

  // The latched word shifts right so the next data bit is always at index 0.
  // This avoids a variable bit select on the word.
  assign shreg_shift = shreg >> 1;
  assign bit_end     = (cnt == CNT_LAST);

  // The next output values are computed together with the next state.
  // This lets every output come from a flop and still change on the same
  // edge as the state.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_n = state;
    cnt_n   = cnt;
    idx_n   = bit_idx;
    shreg_n = shreg;
    pbit_n  = pbit_out;
    tx_n    = tx_out;
    busy_n  = busy;
    ready_n = data_ready;
    done_n  = 1'b0;

    if (state != IDLE) begin
      cnt_n = bit_end ? '0 : cnt + 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (data_valid && data_ready) begin
          state_n = START;
          shreg_n = data_in;
          pbit_n  = gen_pbit;
          tx_n    = START_LEVEL;
          busy_n  = 1'b1;
          ready_n = 1'b0;
          cnt_n   = '0;
          idx_n   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          tx_n    = shreg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == IDX_LAST) begin
            state_n = PARITY;
            tx_n    = pbit_out;
            idx_n   = '0;
          end else begin
            idx_n   = bit_idx + 1'b1;
            shreg_n = shreg_shift;
            tx_n    = shreg_shift[0];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          tx_n    = STOP_LEVEL;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
          tx_n    = LINE_IDLE;
          busy_n  = 1'b0;
          ready_n = 1'b1;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
        tx_n    = LINE_IDLE;
        busy_n  = 1'b0;
        ready_n = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      pbit_out   <= 1'b0;
      tx_out     <= LINE_IDLE;
      busy       <= 1'b0;
      data_ready <= 1'b1;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= idx_n;
      shreg      <= shreg_n;
      pbit_out   <= pbit_n;
      tx_out     <= tx_n;
      busy       <= busy_n;
      data_ready <= ready_n;
      done       <= done_n;
    end
  end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Self-checking bench for parity_serial_tx.
// The main instance uses the default setup: 4 data bits, 4 clocks per
// bit, even parity. The variant instance uses odd parity and 1 clock per
// bit. When a word is accepted, the expected line levels for every cycle
// of its frame are queued. They are popped as the DUT drives the line.
module tb_parity_serial_tx;

  localparam int DW = 4;
  localparam int C  = 4;
  localparam int L  = (DW + 3) * C;
  localparam int CV = 1;
  localparam int LV = (DW + 3) * CV;

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic rst    = 1'b0;

  logic [DW-1:0] data_in    = '0;
  logic          data_valid = 1'b0;
  logic          data_ready, tx_out, busy, pbit_out, done;

  logic [DW-1:0] data_in_v    = '0;
  logic          data_valid_v = 1'b0;
  logic          data_ready_v, tx_out_v, busy_v, pbit_out_v, done_v;

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];

  parity_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(C), .ODD_PARITY(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .tx_out     (tx_out),
    .busy       (busy),
    .pbit_out   (pbit_out),
    .done       (done)
  );

  parity_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CV), .ODD_PARITY(1'b1)) dut_v (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in_v),
    .data_valid (data_valid_v),
    .data_ready (data_ready_v),
    .tx_out     (tx_out_v),
    .busy       (busy_v),
    .pbit_out   (pbit_out_v),
    .done       (done_v)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  function automatic logic model_parity(input logic [DW-1:0] d, input bit odd);
    logic p;
    p = odd;
    for (int k = 0; k < DW; k++) p = p ^ d[k];
    return p;
  endfunction

  function automatic void push_frame(input logic [DW-1:0] d, input bit odd, input int cpb);
    for (int j = 0; j < cpb; j++) exp_q.push_back(1'b0);
    for (int k = 0; k < DW; k++)
      for (int j = 0; j < cpb; j++) exp_q.push_back(d[k]);
    for (int j = 0; j < cpb; j++) exp_q.push_back(model_parity(d, odd));
    for (int j = 0; j < cpb; j++) exp_q.push_back(1'b1);
  endfunction

  // Offer a word at a negedge and return 1 time unit after the edge that takes it.
  task automatic offer(input logic [DW-1:0] d);
    @(negedge clk);
    data_in    = d;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Entered 1 time unit after the acceptance edge.
  // Returns 1 time unit after the done edge.
  task automatic frame_body(input logic [DW-1:0] d, input string name);
    logic [DW-1:0] got_d;
    logic          got_p;
    logic          e;
    logic          exp_p;
    got_d = '0;
    got_p = 1'b0;
    exp_p = model_parity(d, 1'b0);
    push_frame(d, 1'b0, C);

    checks++;
    if (busy !== 1'b1 || data_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: busy=%b data_ready=%b, expected busy=1 data_ready=0", name, busy, data_ready);
    end
    checks++;
    if (pbit_out !== exp_p) begin
      errors++;
      $display("FAIL %s pbit_out: got %b expected %b", name, pbit_out, exp_p);
    end

    for (int i = 0; i < L; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (tx_out !== e) begin
        errors++;
        $display("FAIL %s tx_out cycle %0d: got %b expected %b", name, i, tx_out, e);
      end
      checks++;
      if (done !== 1'b0 || data_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s in-frame flags cycle %0d: done=%b ready=%b busy=%b, expected 0 0 1",
                 name, i, done, data_ready, busy);
      end
      if (i % C == 0) begin
        if (i / C >= 1 && i / C <= DW) got_d[i/C-1] = tx_out;
        if (i / C == DW + 1) got_p = tx_out;
      end
      @(posedge clk);
      #1;
    end

    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || data_ready !== 1'b1 || tx_out !== 1'b1) begin
      errors++;
      $display("FAIL %s end of frame: done=%b busy=%b ready=%b tx=%b, expected 1 0 1 1",
               name, done, busy, data_ready, tx_out);
    end
    // The far-end checker sees the deserialised data plus the parity bit.
    // With even parity it must report no error.
    checks++;
    if (got_d !== d || (^{got_d, got_p}) !== 1'b0) begin
      errors++;
      $display("FAIL %s deserialised: data=%b pbit=%b, expected data=%b with checker error=0",
               name, got_d, got_p, d);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if (tx_out !== 1'b1 || data_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || pbit_out !== 1'b0) begin
      errors++;
      $display("FAIL reset: tx=%b ready=%b busy=%b done=%b pbit=%b, expected 1 1 0 0 0",
               tx_out, data_ready, busy, done, pbit_out);
    end
    checks++;
    if (tx_out_v !== 1'b1 || data_ready_v !== 1'b1 || busy_v !== 1'b0 || done_v !== 1'b0 || pbit_out_v !== 1'b0) begin
      errors++;
      $display("FAIL reset variant: tx=%b ready=%b busy=%b done=%b pbit=%b, expected 1 1 0 0 0",
               tx_out_v, data_ready_v, busy_v, done_v, pbit_out_v);
    end
    #2 rst = 1'b0;
    #2 clk_en = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    offer(4'b0111);
    data_valid = 1'b0;
    frame_body(4'b0111, "basic");
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || pbit_out !== 1'b1 || tx_out !== 1'b1) begin
      errors++;
      $display("FAIL basic after done: done=%b pbit=%b tx=%b, expected 0 1 1", done, pbit_out, tx_out);
    end
  endtask

  task automatic test_parity();
    logic [DW-1:0] words[3] = '{4'b0000, 4'b1111, 4'b0001};
    logic          pbits[3] = '{1'b0, 1'b0, 1'b1};
    for (int t = 0; t < 3; t++) begin
      offer(words[t]);
      data_valid = 1'b0;
      checks++;
      if (pbit_out !== pbits[t]) begin
        errors++;
        $display("FAIL parity word %b: pbit_out=%b expected %b", words[t], pbit_out, pbits[t]);
      end
      frame_body(words[t], "parity");
      @(posedge clk);
    end
  endtask

  task automatic test_back_to_back();
    offer(4'b0001);
    fork
      frame_body(4'b0001, "b2b_first");
      begin
        repeat (8) @(negedge clk);
        data_in = 4'b1110;
        repeat (8) @(negedge clk);
        data_in = 4'b0011;
      end
    join
    // This is the single idle cycle between frames, with valid still high.
    checks++;
    if (tx_out !== 1'b1 || data_ready !== 1'b1 || pbit_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b gap: tx=%b ready=%b pbit=%b, expected 1 1 1", tx_out, data_ready, pbit_out);
    end
    @(posedge clk);
    #1;
    data_in = 4'b0101;
    frame_body(4'b0011, "b2b_second");
    data_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || tx_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b no third frame: busy=%b tx=%b, expected 0 1", busy, tx_out);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    d = 4'b1011;
    offer(d);
    data_valid = 1'b0;
    repeat (13) @(posedge clk);
    #2;
    checks++;
    if (tx_out !== d[2] || busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset pre: tx=%b busy=%b, expected %b 1", tx_out, busy, d[2]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || data_ready !== 1'b1 || done !== 1'b0 || pbit_out !== 1'b0) begin
      errors++;
      $display("FAIL midreset async: tx=%b busy=%b ready=%b done=%b pbit=%b, expected 1 0 1 0 0",
               tx_out, busy, data_ready, done, pbit_out);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || tx_out !== 1'b1) begin
        errors++;
        $display("FAIL midreset hold %0d: done=%b tx=%b, expected 0 1", i, done, tx_out);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || tx_out !== 1'b1) begin
      errors++;
      $display("FAIL midreset release: done=%b busy=%b tx=%b, expected 0 0 1", done, busy, tx_out);
    end
    offer(4'b1010);
    data_valid = 1'b0;
    frame_body(4'b1010, "after_reset");
  endtask

  task automatic test_variant();
    logic e;
    @(negedge clk);
    data_in_v    = 4'b0000;
    data_valid_v = 1'b1;
    push_frame(4'b0000, 1'b1, CV);
    @(posedge clk);
    #1;
    data_valid_v = 1'b0;
    checks++;
    if (pbit_out_v !== 1'b1) begin
      errors++;
      $display("FAIL variant pbit_out: got %b expected 1", pbit_out_v);
    end
    for (int i = 0; i < LV; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (tx_out_v !== e || done_v !== 1'b0) begin
        errors++;
        $display("FAIL variant cycle %0d: tx=%b done=%b, expected tx=%b done=0", i, tx_out_v, done_v, e);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (done_v !== 1'b1 || busy_v !== 1'b0 || tx_out_v !== 1'b1) begin
      errors++;
      $display("FAIL variant end: done=%b busy=%b tx=%b, expected 1 0 1", done_v, busy_v, tx_out_v);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    test_variant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
